// File: rtl/ccu_sequencer.sv
// rtl/ccu_sequencer.sv - instruction sequencer feeding the colour datapath (optional CCU_SEQ_WATCHDOG_EN)
module ccu_sequencer #(
  parameter int          AW         = 8,
  parameter logic [3:0]  NOP_CODE   = 4'hE,
  parameter int          SETTLE_CYC = 1,
  parameter int          WDOG_MAX   = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_valid,
  output logic [3:0]    Abus,
  output logic [3:0]    Bbus,
  output logic [3:0]    Rbus,
  output logic [3:0]    n,
  output logic [7:0]    mData,
  input  logic [3:0]    cc,
`ifdef CCU_SEQ_WATCHDOG_EN
  output logic          wdog_err,
`endif
  output logic [AW-1:0] pc_out
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALT} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [3:0]    settle;
  logic [3:0]    op;
  logic          br_taken;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] br_target;
  logic          settle_last;
  logic          wdog_hit;

  assign op          = ir[15:12];
  assign br_taken    = (cc & ir[11:8]) != 4'd0;
  assign pc_inc      = pc + AW'(1);
  // Offset is relative to the instruction after the branch.
  assign br_target   = pc_inc + AW'($signed(ir[7:0]));
  assign settle_last = (settle == 4'(SETTLE_CYC));

`ifdef CCU_SEQ_WATCHDOG_EN
  logic [15:0] wdog_cnt;
  assign wdog_hit = (wdog_cnt == 16'(WDOG_MAX - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  assign mem_addr = pc;
  assign pc_out   = pc;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_rd   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (mem_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (wdog_hit || op == 4'd15) state_nx = S_HALT;
        else if (op <= 4'd8)         state_nx = S_ISSUE;
        else                         state_nx = S_FETCH;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (settle_last) state_nx = S_FETCH;
      end
      S_HALT: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      settle <= '0;
      Abus   <= '0;
      Bbus   <= '0;
      Rbus   <= '0;
      n      <= NOP_CODE;
      mData  <= '0;
`ifdef CCU_SEQ_WATCHDOG_EN
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc <= start_addr;
`ifdef CCU_SEQ_WATCHDOG_EN
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (mem_valid) ir <= mem_rdata;
        end
        S_DECODE: begin
`ifdef CCU_SEQ_WATCHDOG_EN
          wdog_cnt <= wdog_cnt + 16'd1;
`endif
          settle <= '0;
          if (wdog_hit) begin
`ifdef CCU_SEQ_WATCHDOG_EN
            wdog_err <= 1'b1;
`endif
          end else if (op <= 4'd7) begin
            n    <= op;
            Rbus <= ir[11:8];
            Abus <= ir[7:4];
            Bbus <= ir[3:0];
          end else if (op == 4'd8) begin
            n     <= op;
            Rbus  <= ir[11:8];
            Abus  <= '0;
            Bbus  <= '0;
            mData <= ir[7:0];
          end else if (op == 4'd9) begin
            pc <= br_taken ? br_target : pc_inc;
          end else if (op != 4'd15) begin
            pc <= pc_inc;
          end
        end
        S_ISSUE: begin
          // Only the opcode is withdrawn; operand buses keep their last value.
          if (settle_last) begin
            pc <= pc_inc;
            n  <= NOP_CODE;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_sequencer.sv
// tb/tb_ccu_sequencer.sv - self-checking bench for ccu_sequencer
module tb_ccu_sequencer;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  start_addr;
  logic        busy, done, mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_valid = 1'b0;
  logic [3:0]  Abus, Bbus, Rbus, n;
  logic [7:0]  mData;
  logic [3:0]  cc;
  logic [7:0]  pc_out;
`ifdef CCU_SEQ_WATCHDOG_EN
  logic        wdog_err;
`endif

  always #5 clk = ~clk;

  ccu_sequencer #(.AW(8), .NOP_CODE(4'hE), .SETTLE_CYC(SETTLE), .WDOG_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .Abus(Abus), .Bbus(Bbus), .Rbus(Rbus), .n(n), .mData(mData), .cc(cc),
`ifdef CCU_SEQ_WATCHDOG_EN
    .wdog_err(wdog_err),
`endif
    .pc_out(pc_out)
  );

  typedef struct {
    logic [7:0]  a;
    logic [15:0] w;
    logic [3:0]  c;
    int          l;
    bit          iss;
    logic [3:0]  en, er, ea, eb;
    logic [7:0]  em;
    logic [7:0]  nx;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [256];
  int          lat = 1;

  // Memory responder and bus monitor; only this block writes the totals.
  int         wait_cnt = 0;
  bit         rd_seen = 0;
  logic [7:0] fetch_addr;
  int         fetch_err = 0, unstable = 0, issue_total = 0, done_total = 0, busy_at_done = 0;
  bit         in_issue = 0;
  logic [3:0] cap_n, cap_r, cap_a, cap_b;
  logic [7:0] cap_m, halt_pc;

  always @(negedge clk) begin
    if (mem_rd && rst_n) begin
      if (rd_seen && mem_addr != fetch_addr) fetch_err++;
      rd_seen    = 1;
      fetch_addr = mem_addr;
      if (wait_cnt == lat) begin
        mem_valid = 1'b1;
        mem_rdata = mem[mem_addr];
        wait_cnt  = 0;
        rd_seen   = 0;
      end else begin
        mem_valid = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_valid = 1'b0;
      wait_cnt  = 0;
      rd_seen   = 0;
    end
    if (n != 4'hE) begin
      if (!in_issue) begin
        cap_n = n; cap_r = Rbus; cap_a = Abus; cap_b = Bbus; cap_m = mData;
        in_issue = 1;
      end else if (n != cap_n || Rbus != cap_r || Abus != cap_a || Bbus != cap_b || mData != cap_m) begin
        unstable++;
      end
      issue_total++;
    end else begin
      in_issue = 0;
    end
    if (done) begin
      done_total++;
      halt_pc = pc_out;
      if (busy) busy_at_done++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [15:0] val);
    for (int i = 0; i < 256; i++) mem[i] = val;
  endtask

  task automatic pulse_start(input logic [7:0] a);
    start = 1'b1;
    start_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_total == d0 && k < 300) begin
      tick();
      k++;
    end
    repeat (3) tick();
  endtask

  // Expected behaviour of one instruction followed by HALT, from the instruction rules.
  function automatic vec_t model(input logic [7:0] a, input logic [15:0] w, input logic [3:0] c, input int l);
    vec_t v;
    int   op, off;
    op    = int'(w[15:12]);
    v.a   = a; v.w = w; v.c = c; v.l = l;
    v.iss = (op <= 8);
    v.en  = w[15:12];
    v.er  = w[11:8];
    v.ea  = (op == 8) ? 4'h0 : w[7:4];
    v.eb  = (op == 8) ? 4'h0 : w[3:0];
    v.em  = w[7:0];
    off   = w[7] ? int'(w[7:0]) - 256 : int'(w[7:0]);
    if (op == 9 && (c & w[11:8]) != 4'h0) v.nx = 8'((int'(a) + 1 + off + 256) % 256);
    else                                   v.nx = 8'((int'(a) + 1) % 256);
    return v;
  endfunction

  task automatic exec(input string tag, input vec_t v);
    int d0, i0, f0, u0, b0;
    fill(16'hF000);
    mem[v.a] = v.w;
    cc  = v.c;
    lat = v.l;
    d0 = done_total; i0 = issue_total; f0 = fetch_err; u0 = unstable; b0 = busy_at_done;
    pulse_start(v.a);
    wait_done(d0);
    check({tag, "_done_once"}, done_total - d0, 1);
    check({tag, "_halt_pc"}, halt_pc, v.nx);
    check({tag, "_issue_cycles"}, issue_total - i0, v.iss ? 1 + SETTLE : 0);
    if (v.iss) begin
      check({tag, "_n"}, cap_n, v.en);
      check({tag, "_rbus"}, cap_r, v.er);
      check({tag, "_abus"}, cap_a, v.ea);
      check({tag, "_bbus"}, cap_b, v.eb);
      if (v.en == 4'h8) check({tag, "_mdata"}, cap_m, v.em);
    end
    check({tag, "_fetch_stable"}, fetch_err - f0, 0);
    check({tag, "_fields_stable"}, unstable - u0, 0);
    check({tag, "_busy_at_done"}, busy_at_done - b0, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_n_after"}, n, 4'hE);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    int d0;
    tbl[0] = '{8'h10, 16'h8A3C, 4'h0, 1, 1'b1, 4'h8, 4'hA, 4'h0, 4'h0, 8'h3C, 8'h11};
    tbl[1] = '{8'h30, 16'h2912, 4'h0, 3, 1'b1, 4'h2, 4'h9, 4'h1, 4'h2, 8'h00, 8'h31};
    tbl[2] = '{8'h20, 16'h94FE, 4'h4, 1, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 8'h1F};
    tbl[3] = '{8'h20, 16'h94FE, 4'h3, 2, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 8'h21};
    tbl[4] = '{8'hFF, 16'hE000, 4'h0, 1, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
    tbl[5] = '{8'h40, 16'h7FAB, 4'h0, 2, 1'b1, 4'h7, 4'hF, 4'hA, 4'hB, 8'h00, 8'h41};
    tbl[6] = '{8'h50, 16'h9F7F, 4'hF, 1, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 8'hD0};
    tbl[7] = '{8'h60, 16'h9180, 4'h1, 1, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 8'hE1};
    tbl[8] = '{8'h70, 16'h0123, 4'h0, 1, 1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 8'h00, 8'h71};
    tbl[9] = '{8'h80, 16'h9F05, 4'h0, 1, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 8'h81};

    rst_n = 1'b0; start = 1'b0; start_addr = 8'h0; cc = 4'h0;
    fill(16'hF000);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_buses", {Abus, Bbus, Rbus}, 0);
    check("rst_n", n, 4'hE);
    check("rst_mdata", mData, 0);
    check("rst_pc_out", pc_out, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) exec($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      logic [7:0]  a;
      logic [15:0] w;
      logic [3:0]  c;
      a = 8'($urandom_range(0, 255));
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      c = 4'($urandom);
      rv = model(a, w, c, $urandom_range(1, 4));
      if (rv.nx == a) rv = model(a, w, 4'h0, rv.l);
      exec($sformatf("rnd%0d", i), rv);
    end

    // A second start while busy must not redirect the program.
    fill(16'hF000);
    mem[8'hA0] = 16'h8123;
    lat = 3;
    d0 = done_total;
    pulse_start(8'hA0);
    tick();
    check("busy_during_run", busy, 1);
    pulse_start(8'hB0);
    wait_done(d0);
    check("restart_done_once", done_total - d0, 1);
    check("restart_halt_pc", halt_pc, 8'hA1);

    // Reset in the middle of ISSUE.
    fill(16'hF000);
    mem[8'h90] = 16'h8555;
    lat = 1;
    d0 = done_total;
    pulse_start(8'h90);
    for (int k = 0; k < 50 && n == 4'hE; k++) tick();
    check("rst_mid_in_issue", n, 4'h8);
    rst_n = 1'b0;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem_rd", mem_rd, 0);
    check("rst_mid_n", n, 4'hE);
    check("rst_mid_rbus_mdata", {Rbus, mData}, 0);
    check("rst_mid_pc_out", pc_out, 0);
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_mid_no_done", done_total - d0, 0);
    check("rst_mid_idle", busy, 0);

`ifdef CCU_SEQ_WATCHDOG_EN
    fill(16'hE000);
    lat = 1;
    d0 = done_total;
    pulse_start(8'h00);
    wait_done(d0);
    check("wdog_done_once", done_total - d0, 1);
    check("wdog_halt_pc", halt_pc, 8'h03);
    check("wdog_err_set", wdog_err, 1);
    fill(16'hF000);
    d0 = done_total;
    pulse_start(8'h05);
    check("wdog_err_cleared", wdog_err, 0);
    wait_done(d0);
    check("wdog_normal_halt_pc", halt_pc, 8'h05);
    check("wdog_err_stays_low", wdog_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
